interrupt_controller: RTL



---
 rtl/interrupt_controller_if.sv | 28 ++
 rtl/interrupt_controller.sv | 107 ++++++++++
 2 files changed

// File: rtl/interrupt_controller_if.sv
// CPU-side bundle of the interrupt controller: boundary/PC/eret from the core,
// redirect and trap-state signals back to it.
interface interrupt_controller_if #(
    parameter int NUM_SRC  = 4,
    parameter int PC_WIDTH = 32
);
    localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic                instr_boundary;
    logic [PC_WIDTH-1:0] cur_pc;
    logic                eret;
    logic                irq_req;
    logic                take;
    logic [PC_WIDTH-1:0] vector;
    logic [PC_WIDTH-1:0] epc;
    logic [CW-1:0]       cause;
    logic                in_handler;

    modport master (
        output instr_boundary, cur_pc, eret,
        input  irq_req, take, vector, epc, cause, in_handler
    );

    modport slave (
        input  instr_boundary, cur_pc, eret,
        output irq_req, take, vector, epc, cause, in_handler
    );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller that redirects the
// core to a per-source vector at instruction boundaries, without nesting.
module interrupt_controller #(
    parameter int                  NUM_SRC    = 4,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned         VEC_STRIDE = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    irq_in,
    input  logic                  mask_we,
    input  logic [NUM_SRC-1:0]    mask_wdata,
    input  logic                  gie_set,
    input  logic                  gie_clr,
    output logic [NUM_SRC-1:0]    pending,
    output logic [NUM_SRC-1:0]    mask,
    output logic                  gie,
    interrupt_controller_if.slave cpu
);
    localparam int CW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, HANDLER} state_t;

    state_t             state, state_next;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] take_clr;
    logic [CW-1:0]      win;
    logic               found;
    logic               fire;
    logic               eret_ok;

    assign rise     = irq_in & ~prev;
    assign eligible = gie ? (pending & mask) : '0;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && !found) begin
                win   = CW'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        fire       = 1'b0;
        eret_ok    = 1'b0;
        case (state)
            IDLE:    if (|eligible) state_next = ARMED;
            ARMED: begin
                if (~|eligible) begin
                    state_next = IDLE;
                end else if (cpu.instr_boundary) begin
                    fire       = 1'b1;
                    state_next = HANDLER;
                end
            end
            HANDLER: begin
                if (cpu.eret) begin
                    eret_ok    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign take_clr       = fire ? (NUM_SRC'(1) << win) : '0;
    assign cpu.irq_req    = (state == ARMED);
    assign cpu.in_handler = (state == HANDLER);

    always_ff @(posedge clock) begin
        if (reset) begin
            prev       <= '0;
            pending    <= '0;
            mask       <= '0;
            gie        <= 1'b0;
            cpu.take   <= 1'b0;
            cpu.epc    <= '0;
            cpu.cause  <= '0;
            cpu.vector <= '0;
        end else begin
            prev     <= irq_in;
            // A fresh edge on the source being taken re-arms its pending bit.
            pending  <= (pending & ~take_clr) | rise;
            if (mask_we) mask <= mask_wdata;
            if (fire || gie_clr)        gie <= 1'b0;
            else if (gie_set || eret_ok) gie <= 1'b1;
            cpu.take <= fire;
            if (fire) begin
                cpu.epc    <= cpu.cur_pc;
                cpu.cause  <= win;
                cpu.vector <= VEC_BASE + PC_WIDTH'(win) * PC_WIDTH'(VEC_STRIDE);
            end
        end
    end
endmodule
